fetch_decode_skid: RTL
======================

Name: fetch_decode_skid

Overview:
- 2-entry skid buffer: the IF/ID pipeline boundary of the MIPS-32 core.
- Accepts fetched instructions and PCs on a valid/ready handshake.
- Extracts the 3-bit major-opcode group (instr[31:29]) that drives the downstream 3-to-8 opcode-group decoder.
- Registers all outputs, so fetch and decode timing are isolated. Supports pipeline flush on branch/jump redirect.

Parameters:
- INSTR_W, 32, instruction width in bits.
- PC_W, 32, program-counter width in bits.
- SEL_LSB, 29, LSB of the 3-bit group field; out_sel = instr[SEL_LSB+2:SEL_LSB].

Ports:
- clk  in  1  core clock, rising edge.
- rst_n  in  1  asynchronous active-low reset.
- flush  in  1  discard all buffered instructions this cycle.
- in_valid  in  1  fetch presents an instruction.
- in_ready  out  1  buffer can accept; registered.
- in_instr  in  INSTR_W  fetched instruction.
- in_pc  in  PC_W  PC of in_instr.
- out_valid  out  1  decode-side entry valid.
- out_ready  in  1  decode consumes the entry.
- out_instr  out  INSTR_W  instruction to decode.
- out_pc  out  PC_W  PC of out_instr.
- out_sel  out  3  opcode group field, to the group decoder W input.

Behaviour:
- Storage: main slot (drives the outputs) and skid slot. Each slot holds instr, pc, sel and a valid bit.
- Reset (async, rst_n=0): both valid bits 0, out_valid=0, in_ready=1, out_instr=0, out_pc=0, out_sel=3'b000.
- Transfer in: in_valid & in_ready. Transfer out: out_valid & out_ready.
- Latency: an instruction accepted at edge N appears on the outputs after edge N (one cycle), provided the main slot is empty or draining.
- in_ready is a flop. It is 1 iff the skid slot is empty after the current edge. It never combinationally depends on out_ready.
- Slot occupancy states are EMPTY, ONE and FULL. Transitions per edge:
  - EMPTY + transfer-in -> ONE (load main).
  - ONE + in only -> FULL (load skid).
  - ONE + out only -> EMPTY.
  - ONE + in + out -> ONE (main reloads from input).
  - FULL + out -> ONE (skid moves to main; in_ready=0 in FULL, so no input is accepted).
  - No transfer: hold.
- out_sel is computed at load time from the stored instr and registered with it. It is never combinational from in_instr.
- When out_valid=0, the data outputs hold their last value. The consumer must qualify them with out_valid.
- Flush is synchronous. It has priority over every simultaneous transfer:
  - Both valids clear, state -> EMPTY, in_ready=1 next cycle.
  - Any in-flight input that cycle is dropped.
  - Data registers are not cleared.
- Order is preserved strictly FIFO, with no duplication or loss except by flush.
- Reset mid-operation discards everything immediately; outputs are at reset values while rst_n is low.

Optional Feature:
- Macro: FETCH_DECODE_SKID_PERF_EN.
- Defined:
  - Adds output port stall_cnt (16 bits): counts cycles with out_valid=1 & out_ready=0.
  - Saturates at 16'hFFFF.
  - Cleared only by reset; unaffected by flush.
- Undefined: the port and counter are absent. All other behaviour is identical.

Decomposition:
- Shared package mips_pipe_pkg:
  - localparams INSTR_W=32, PC_W=32, SEL_W=3, SEL_LSB=29.
  - packed struct if_id_entry_t {instr, pc, sel}.
  - typedef skid_state_t enum {EMPTY, ONE, FULL}.
- One sub-module is natural: skid_slot (an entry register with valid, load enable and clear).

Test Plan:
- Reset with rst_n=0 mid-stream while FULL -> out_valid=0, in_ready=1, out_sel=3'b000 immediately (async).
- Stream instr 32'h8C220004 (lw), 32'h20420001 (addi), 32'hAC220008 (sw) with out_ready=1 -> each appears one cycle after acceptance with out_sel 3'b100, 3'b001, 3'b101, one per cycle, no bubbles.
- Hold out_ready=0 and offer 3 instructions -> first two accepted, in_ready=0 after second. Release out_ready -> outputs in order with PCs 0x0, 0x4, 0x8; third accepted only once in_ready returns to 1.
- Assert flush together with in_valid=1 while FULL -> next cycle out_valid=0, in_ready=1. The flushed and incoming instructions never appear.
- Simultaneous in and out transfer in state ONE -> state stays ONE, out_instr updates to the new instruction, in_ready stays 1.
- With FETCH_DECODE_SKID_PERF_EN, hold out_ready=0 for 70000 cycles with out_valid=1 -> stall_cnt=16'hFFFF. A flush leaves it unchanged.

Source files
------------

// File: rtl/mips_pipe_pkg.sv
// rtl/mips_pipe_pkg.sv - shared IF/ID pipeline types and widths
package mips_pipe_pkg;

  localparam int INSTR_W = 32;
  localparam int PC_W    = 32;
  localparam int SEL_W   = 3;
  localparam int SEL_LSB = 29;

  typedef struct packed {
    logic [INSTR_W-1:0] instr;
    logic [PC_W-1:0]    pc;
    logic [SEL_W-1:0]   sel;
  } if_id_entry_t;

  typedef enum logic [1:0] {
    EMPTY = 2'd0,
    ONE   = 2'd1,
    FULL  = 2'd2
  } skid_state_t;

endpackage

// File: rtl/skid_slot.sv
// rtl/skid_slot.sv - one IF/ID entry register with valid, load and clear
module skid_slot
  import mips_pipe_pkg::*;
(
  input  logic         clk,
  input  logic         rst_n,
  input  logic         load,
  input  logic         clr,
  input  if_id_entry_t d,
  output logic         valid,
  output if_id_entry_t q
);

  // clr only drops the valid bit; the data keeps its last value
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      valid <= 1'b0;
      q     <= '0;
    end else begin
      if (clr) begin
        valid <= 1'b0;
      end else if (load) begin
        valid <= 1'b1;
      end
      if (load && !clr) begin
        q <= d;
      end
    end
  end

endmodule

// File: rtl/fetch_decode_skid.sv
// rtl/fetch_decode_skid.sv - IF/ID 2-entry skid buffer; FETCH_DECODE_SKID_PERF_EN adds stall_cnt
module fetch_decode_skid #(
  parameter int INSTR_W = mips_pipe_pkg::INSTR_W,
  parameter int PC_W    = mips_pipe_pkg::PC_W,
  parameter int SEL_LSB = mips_pipe_pkg::SEL_LSB
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               flush,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic [INSTR_W-1:0] in_instr,
  input  logic [PC_W-1:0]    in_pc,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [INSTR_W-1:0] out_instr,
  output logic [PC_W-1:0]    out_pc,
  output logic [2:0]         out_sel
`ifdef FETCH_DECODE_SKID_PERF_EN
  ,
  output logic [15:0]        stall_cnt
`endif
);

  import mips_pipe_pkg::*;

  skid_state_t  state_q, state_d;
  if_id_entry_t in_entry, main_d, main_q, skid_q;
  logic main_v, skid_v;
  logic main_load, main_clr, main_from_skid, skid_load, skid_clr;
  logic in_fire, out_fire;

  assign in_fire  = in_valid & in_ready;
  assign out_fire = main_v & out_ready;

  // group field is captured at load time so out_sel is purely registered
  always_comb begin
    in_entry       = '0;
    in_entry.instr = in_instr;
    in_entry.pc    = in_pc;
    in_entry.sel   = in_instr[SEL_LSB+2:SEL_LSB];
  end

  assign main_d = main_from_skid ? skid_q : in_entry;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= EMPTY;
      in_ready <= 1'b1;
    end else begin
      state_q  <= state_d;
      in_ready <= (state_d != FULL);
    end
  end

  always_comb begin
    state_d        = state_q;
    main_load      = 1'b0;
    main_clr       = flush;
    main_from_skid = 1'b0;
    skid_load      = 1'b0;
    skid_clr       = flush;
    if (flush) begin
      state_d = EMPTY;
    end else begin
      unique case (state_q)
        EMPTY: begin
          if (in_fire) begin
            main_load = 1'b1;
            state_d   = ONE;
          end
        end
        ONE: begin
          if (in_fire && out_fire) begin
            main_load = 1'b1;
          end else if (in_fire) begin
            skid_load = 1'b1;
            state_d   = FULL;
          end else if (out_fire) begin
            main_clr = 1'b1;
            state_d  = EMPTY;
          end
        end
        FULL: begin
          if (out_fire) begin
            main_load      = 1'b1;
            main_from_skid = 1'b1;
            skid_clr       = 1'b1;
            state_d        = ONE;
          end
        end
        default: state_d = EMPTY;
      endcase
    end
  end

  skid_slot u_main (
    .clk   (clk),
    .rst_n (rst_n),
    .load  (main_load),
    .clr   (main_clr),
    .d     (main_d),
    .valid (main_v),
    .q     (main_q)
  );

  skid_slot u_skid (
    .clk   (clk),
    .rst_n (rst_n),
    .load  (skid_load),
    .clr   (skid_clr),
    .d     (in_entry),
    .valid (skid_v),
    .q     (skid_q)
  );

  assign out_valid = main_v;
  assign out_instr = main_q.instr;
  assign out_pc    = main_q.pc;
  assign out_sel   = main_q.sel;

`ifdef FETCH_DECODE_SKID_PERF_EN
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      stall_cnt <= '0;
    end else if (main_v && !out_ready && stall_cnt != 16'hFFFF) begin
      stall_cnt <= stall_cnt + 16'd1;
    end
  end
`endif

endmodule
